mux_3x16_arb: RTL and testbench

- Round-robin arbiter that shares the 3-input 16-bit datapath mux (mux_3x16) between three requesters.
- Grants the mux to one requester at a time and drives the mux select.
- Grant is held until the owner releases it, or until the optional hold-limit timeout expires.
- Sits beside mux_3x16 in the mycpu datapath; its sel_out connects directly to the mux sel_in.

---
 rtl/mycpu_pkg.sv | 24 ++
 rtl/rr_pick_3.sv | 40 ++++
 rtl/mux_3x16_arb.sv | 141 ++++++++++++++
 tb/tb_mux_3x16_arb.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared types and helpers for the mycpu mux arbiter slice.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: arb_state_t, MUX_SEL_* select encodings, onehot_to_sel().
package mycpu_pkg;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   localparam logic [1:0] MUX_SEL_D0 = 2'b00;
   localparam logic [1:0] MUX_SEL_D1 = 2'b01;
   localparam logic [1:0] MUX_SEL_D2 = 2'b10;

   // Map a 3-bit one-hot grant to the mux select; zero maps to d0.
   function automatic logic [1:0] onehot_to_sel(input logic [2:0] oh);
      logic [1:0] sel;
      case (oh)
         3'b010:  sel = MUX_SEL_D1;
         3'b100:  sel = MUX_SEL_D2;
         default: sel = MUX_SEL_D0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/rr_pick_3.sv
// Rotating-priority picker for three requesters.
// Latency: purely combinational.
// Backpressure: none; the winner is a function of req and last only.
// Ports: req[2:0] requests, last[1:0] previous owner (scan starts at last+1 mod 3),
//        win_onehot[2:0] winner, win_idx[1:0] winner index, any = some request set.
module rr_pick_3
   import mycpu_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [2:0] win_onehot,
   output logic [1:0] win_idx,
   output logic       any
);

   always_comb begin
      win_onehot = 3'b000;
      case (last)
         2'd0: begin
            if      (req[1]) win_onehot = 3'b010;
            else if (req[2]) win_onehot = 3'b100;
            else if (req[0]) win_onehot = 3'b001;
         end
         2'd1: begin
            if      (req[2]) win_onehot = 3'b100;
            else if (req[0]) win_onehot = 3'b001;
            else if (req[1]) win_onehot = 3'b010;
         end
         default: begin
            if      (req[0]) win_onehot = 3'b001;
            else if (req[1]) win_onehot = 3'b010;
            else if (req[2]) win_onehot = 3'b100;
         end
      endcase
   end

   assign win_idx = onehot_to_sel(win_onehot);
   assign any     = |req;

endmodule

// File: rtl/mux_3x16_arb.sv
// Round-robin owner arbiter for the shared 3x16 datapath mux; drives the mux select.
// Latency: request to grant 1 cycle; release hands over on the same edge (no bubble).
// Backpressure: owner keeps the grant until done/req drop (or hold-limit timeout).
// Ports: clk, rst (sync, active-high), req_in[2:0], done_in[2:0] -> gnt_out[2:0],
//        sel_out[1:0], busy_out, preempt_out.
// Build option: MYCPU_ARB_TIMEOUT_EN enables hold-limit preemption (MAX_HOLD cycles).
module mux_3x16_arb
   import mycpu_pkg::*;
#(
   parameter int N_REQ    = 3,
   parameter int MAX_HOLD = 4
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req_in,
   input  logic [2:0] done_in,
   output logic [2:0] gnt_out,
   output logic [1:0] sel_out,
   output logic       busy_out,
   output logic       preempt_out
);

   if (N_REQ != 3 || MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_param
      $error("mux_3x16_arb: N_REQ must be 3 and MAX_HOLD in 1..15");
   end

   arb_state_t state_q, state_d;
   logic [2:0] gnt_q, gnt_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] last_q, last_d;

   logic [1:0] pick_last;
   logic [2:0] win_onehot;
   logic [1:0] win_idx;
   logic       win_any;
   logic       owner_rel;
   logic       others_pend;

   // While granted, rotate from the current owner so a release or revoke
   // hands over to the next requester; the owner only wins if it is alone.
   assign pick_last = (state_q == ARB_GRANT) ? sel_q : last_q;

   rr_pick_3 u_pick (
      .req        (req_in),
      .last       (pick_last),
      .win_onehot (win_onehot),
      .win_idx    (win_idx),
      .any        (win_any)
   );

   assign owner_rel   = (|(done_in & gnt_q)) | ~(|(req_in & gnt_q));
   assign others_pend = |(req_in & ~gnt_q);

`ifdef MYCPU_ARB_TIMEOUT_EN
   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
   logic [3:0] hold_q, hold_d;
   logic       preempt_q, preempt_d;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
`ifdef MYCPU_ARB_TIMEOUT_EN
      hold_d    = hold_q;
      preempt_d = 1'b0;
`endif
      if (state_q == ARB_IDLE) begin
         if (win_any) begin
            state_d = ARB_GRANT;
            gnt_d   = win_onehot;
            sel_d   = win_idx;
`ifdef MYCPU_ARB_TIMEOUT_EN
            hold_d  = 4'd0;
`endif
         end
      end else if (owner_rel) begin
         last_d = sel_q;
         if (win_any) begin
            gnt_d  = win_onehot;
            sel_d  = win_idx;
`ifdef MYCPU_ARB_TIMEOUT_EN
            hold_d = 4'd0;
`endif
         end else begin
            // sel_out keeps pointing at the last owner while idle
            state_d = ARB_IDLE;
            gnt_d   = 3'b000;
         end
      end
`ifdef MYCPU_ARB_TIMEOUT_EN
      else if (others_pend) begin
         if (hold_q == HOLD_LAST) begin
            last_d    = sel_q;
            gnt_d     = win_onehot;
            sel_d     = win_idx;
            hold_d    = 4'd0;
            preempt_d = 1'b1;
         end else if (hold_q != 4'hF) begin
            hold_d = hold_q + 4'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         gnt_q   <= 3'b000;
         sel_q   <= MUX_SEL_D0;
         last_q  <= 2'd2;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
      end
   end

`ifdef MYCPU_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q    <= 4'd0;
         preempt_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end
   assign preempt_out = preempt_q;
`else
   assign preempt_out = 1'b0;
`endif

   assign gnt_out  = gnt_q;
   assign sel_out  = sel_q;
   assign busy_out = |gnt_q;

endmodule

// File: tb/tb_mux_3x16_arb.sv
// Directed and random bench for the 3-way round-robin mux arbiter.
// Latency: checks 1-cycle grant and same-edge handover.
// Backpressure: n/a.
module tb_mux_3x16_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_in;
   logic [2:0]  done_in;
   logic [2:0]  gnt_out;
   logic [1:0]  sel_out;
   logic        busy_out;
   logic        preempt_out;

   int n_assert = 0;
   int n_fail   = 0;

   // behavioural stand-in for the 3x16 datapath mux fed by sel_out
   logic [15:0] d0 = 16'hA000, d1 = 16'hB111, d2 = 16'hC222;
   logic [15:0] m_out;
   assign m_out = (sel_out == 2'b00) ? d0 : (sel_out == 2'b01) ? d1 : d2;

   always #5 clk = ~clk;

   mux_3x16_arb #(.N_REQ(3), .MAX_HOLD(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_in      (req_in),
      .done_in     (done_in),
      .gnt_out     (gnt_out),
      .sel_out     (sel_out),
      .busy_out    (busy_out),
      .preempt_out (preempt_out)
   );

   a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_out))
      else $error("FAIL sva_onehot gnt_out=%b", gnt_out);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] exp_sel(input logic [2:0] g);
      return (g == 3'b010) ? 2'b01 : (g == 3'b100) ? 2'b10 : 2'b00;
   endfunction

   initial begin
      int wait_cnt [3];
      int max_wait;
      int bad_inv;
      int pre_seen;
      logic [2:0] prev_gnt;
      logic [2:0] req_app;

      rst = 1'b1; req_in = 3'b000; done_in = 3'b000;
      step(); step();
      chk("rst_gnt", 32'(gnt_out), 32'h0);
      chk("rst_sel", 32'(sel_out), 32'h0);
      chk("rst_busy", 32'(busy_out), 32'h0);
      chk("rst_preempt", 32'(preempt_out), 32'h0);

      // single request from requester 1
      rst = 1'b0; req_in = 3'b010;
      step();
      chk("t1_gnt", 32'(gnt_out), 32'h2);
      chk("t1_sel", 32'(sel_out), 32'h1);
      chk("t1_busy", 32'(busy_out), 32'h1);
      chk("t1_mout", 32'(m_out), 32'hB111);
      req_in = 3'b000;
      step();
      chk("t1_idle_gnt", 32'(gnt_out), 32'h0);
      chk("t1_idle_busy", 32'(busy_out), 32'h0);
      chk("t1_idle_sel", 32'(sel_out), 32'h1);

      // all requesting, owner pulses done: 0,1,2,0 back-to-back
      rst = 1'b1; step(); rst = 1'b0;
      req_in = 3'b111;
      step();
      chk("rr_g0", 32'(gnt_out), 32'h1); chk("rr_s0", 32'(sel_out), 32'h0);
      done_in = 3'b001; step();
      chk("rr_g1", 32'(gnt_out), 32'h2); chk("rr_s1", 32'(sel_out), 32'h1);
      done_in = 3'b010; step();
      chk("rr_g2", 32'(gnt_out), 32'h4); chk("rr_s2", 32'(sel_out), 32'h2);
      done_in = 3'b100; step();
      chk("rr_g3", 32'(gnt_out), 32'h1); chk("rr_s3", 32'(sel_out), 32'h0);
      chk("rr_busy", 32'(busy_out), 32'h1);

      // move to owner 2, then non-owner done, then owner drops req
      done_in = 3'b001; step();
      done_in = 3'b010; req_in = 3'b100; step();
      chk("no_g2", 32'(gnt_out), 32'h4);
      done_in = 3'b001; step();
      chk("nonowner_done", 32'(gnt_out), 32'h4);
      done_in = 3'b000; req_in = 3'b000; step();
      chk("drop_gnt", 32'(gnt_out), 32'h0);
      chk("drop_sel", 32'(sel_out), 32'h2);
      chk("drop_busy", 32'(busy_out), 32'h0);
      done_in = 3'b111; step();
      chk("idle_done_ign", 32'(gnt_out), 32'h0);
      done_in = 3'b000;

      // hold limit: owner 0 keeps requesting while 1 waits
      req_in = 3'b011; step();
      chk("hold_g0", 32'(gnt_out), 32'h1);
`ifdef MYCPU_ARB_TIMEOUT_EN
      pre_seen = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (gnt_out != 3'b001 || preempt_out) pre_seen++;
      end
      chk("hold_early", 32'(pre_seen), 32'h0);
      step();
      chk("to_gnt", 32'(gnt_out), 32'h2);
      chk("to_preempt", 32'(preempt_out), 32'h1);
      step();
      chk("to_pulse_end", 32'(preempt_out), 32'h0);
      chk("to_gnt_held", 32'(gnt_out), 32'h2);
`else
      pre_seen = 0;
      for (int k = 0; k < 22; k++) begin
         step();
         if (gnt_out != 3'b001 || preempt_out) pre_seen++;
      end
      chk("hold_forever", 32'(pre_seen), 32'h0);
      chk("hold_gnt", 32'(gnt_out), 32'h1);
`endif
      req_in = 3'b000; step();
      chk("hold_release", 32'(gnt_out), 32'h0);

      // reset while requester 1 owns the mux
      req_in = 3'b010; step();
      chk("mid_g1", 32'(gnt_out), 32'h2);
      rst = 1'b1; step();
      chk("mid_rst_gnt", 32'(gnt_out), 32'h0);
      chk("mid_rst_sel", 32'(sel_out), 32'h0);
      chk("mid_rst_busy", 32'(busy_out), 32'h0);
      rst = 1'b0; req_in = 3'b011; step();
      chk("post_rst_g0", 32'(gnt_out), 32'h1);

      // random traffic: invariants and starvation bound
      wait_cnt[0] = 0; wait_cnt[1] = 0; wait_cnt[2] = 0;
      max_wait = 0; bad_inv = 0;
      prev_gnt = gnt_out;
      for (int c = 0; c < 3000; c++) begin
         req_app = 3'($urandom_range(0, 7));
         req_in  = req_app;
         done_in = 3'($urandom_range(0, 7));
         step();
         if (!$onehot0(gnt_out)) bad_inv++;
         if (gnt_out != 3'b000 && sel_out != exp_sel(gnt_out)) bad_inv++;
         if (sel_out == 2'b11) bad_inv++;
         if (busy_out != (gnt_out != 3'b000)) bad_inv++;
         for (int i = 0; i < 3; i++) begin
            if (gnt_out[i] || !req_app[i]) wait_cnt[i] = 0;
            else if (gnt_out != prev_gnt && gnt_out != 3'b000) wait_cnt[i]++;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
         end
         prev_gnt = gnt_out;
      end
      chk("rand_invariants", 32'(bad_inv), 32'h0);
      n_assert++;
      assert (max_wait <= 4) else begin
         n_fail++;
         $error("FAIL starvation: observed max wait %0d grants, limit 4", max_wait);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
